// File: rtl/sar_pkg.sv
// Shared types and helpers for the SAR conversion engine.
//   state_t    : FSM encoding (IDLE / CONVERT / DONE)
//   idx_width  : index width for n items, never below 1 bit
//   slice_lsb  : LSB position of channel ch inside the flat result bank
package sar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned slice_lsb(input int unsigned ch, input int unsigned res_bits);
        return ch * res_bits;
    endfunction

endpackage

// File: rtl/sar_result_bank.sv
// Per-channel result register file.
//   clk, reset : clock, async active-high reset (clears every entry)
//   we         : write enable for one entry
//   wch, wdata : entry index and code to store
//   results    : flat read-out, channel k at [k*RES_BITS +: RES_BITS]
module sar_result_bank
    import sar_pkg::*;
#(
    parameter  int unsigned NUM_CH   = 8,
    parameter  int unsigned RES_BITS = 10,
    localparam int unsigned CH_W     = idx_width(NUM_CH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       we,
    input  logic [CH_W-1:0]            wch,
    input  logic [RES_BITS-1:0]        wdata,
    output logic [NUM_CH*RES_BITS-1:0] results
);

    // Each entry is only touched when its own channel is written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            results <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (we && (wch == CH_W'(k))) begin
                    results[slice_lsb(k, RES_BITS) +: RES_BITS] <= wdata;
                end
            end
        end
    end

endmodule

// File: rtl/sar_collector.sv
// SAR conversion engine with per-channel result bank.
//   clk, reset      : clock, async active-high reset
//   start, ch_sel   : request a conversion of ch_sel (IDLE only)
//   scan_en         : after each accepted result, auto-convert the next channel
//   abort           : cancel a conversion in progress
//   cmp             : comparator decision for dac_code (1 = Vin >= Vdac)
//   dac_code        : current trial code, bit_onehot: bit under test
//   busy            : high in CONVERT and DONE
//   result_*        : valid/ready result handshake with channel and code
//   results         : flat bank of the last code per channel
module sar_collector
    import sar_pkg::*;
#(
    parameter  int unsigned NUM_CH   = 8,
    parameter  int unsigned RES_BITS = 10,
    localparam int unsigned CH_W     = idx_width(NUM_CH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [CH_W-1:0]            ch_sel,
    input  logic                       scan_en,
    input  logic                       abort,
    input  logic                       cmp,
    output logic [RES_BITS-1:0]        dac_code,
    output logic [RES_BITS-1:0]        bit_onehot,
    output logic                       busy,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic [CH_W-1:0]            result_ch,
    output logic [RES_BITS-1:0]        result_data,
    output logic [NUM_CH*RES_BITS-1:0] results
);

    localparam int unsigned         IDX_W    = idx_width(RES_BITS);
    localparam logic [RES_BITS-1:0] MSB_CODE = RES_BITS'(1) << (RES_BITS - 1);
    localparam logic [IDX_W-1:0]    MSB_IDX  = IDX_W'(RES_BITS - 1);
    localparam logic [CH_W-1:0]     LAST_CH  = CH_W'(NUM_CH - 1);

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    bit_idx, bit_idx_nxt;
    logic [CH_W-1:0]     cur_ch, cur_ch_nxt;
    logic [RES_BITS-1:0] dac_nxt, onehot_nxt, data_nxt;
    logic [CH_W-1:0]     rch_nxt;
    logic                busy_nxt, valid_nxt;
    logic [RES_BITS-1:0] code_c;
    logic                start_ok_c;
    logic                bank_we_c;

    // Out-of-range channel requests are dropped.
    assign start_ok_c = start && ({1'b0, ch_sel} < (CH_W + 1)'(NUM_CH));

    // Trial code with the bit under test resolved by the comparator.
    assign code_c = (dac_code & ~bit_onehot) | (cmp ? bit_onehot : '0);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt   = state;
        bit_idx_nxt = bit_idx;
        cur_ch_nxt  = cur_ch;
        dac_nxt     = dac_code;
        onehot_nxt  = bit_onehot;
        busy_nxt    = busy;
        valid_nxt   = result_valid;
        rch_nxt     = result_ch;
        data_nxt    = result_data;
        bank_we_c   = 1'b0;

        case (state)
            ST_IDLE: begin
                // start beats a simultaneous abort here
                if (start_ok_c) begin
                    state_nxt   = ST_CONVERT;
                    cur_ch_nxt  = ch_sel;
                    bit_idx_nxt = MSB_IDX;
                    dac_nxt     = MSB_CODE;
                    onehot_nxt  = MSB_CODE;
                    busy_nxt    = 1'b1;
                end
            end
            ST_CONVERT: begin
                if (abort) begin
                    state_nxt  = ST_IDLE;
                    dac_nxt    = '0;
                    onehot_nxt = '0;
                    busy_nxt   = 1'b0;
                end else if (bit_idx == '0) begin
                    state_nxt  = ST_DONE;
                    dac_nxt    = code_c;
                    onehot_nxt = '0;
                    valid_nxt  = 1'b1;
                    rch_nxt    = cur_ch;
                    data_nxt   = code_c;
                    bank_we_c  = 1'b1;
                end else begin
                    bit_idx_nxt = bit_idx - IDX_W'(1);
                    dac_nxt     = code_c | (bit_onehot >> 1);
                    onehot_nxt  = bit_onehot >> 1;
                end
            end
            ST_DONE: begin
                // result_valid is always set in DONE, so ready alone completes it
                if (result_ready) begin
                    valid_nxt = 1'b0;
                    if (scan_en) begin
                        state_nxt   = ST_CONVERT;
                        cur_ch_nxt  = (cur_ch == LAST_CH) ? '0 : cur_ch + CH_W'(1);
                        bit_idx_nxt = MSB_IDX;
                        dac_nxt     = MSB_CODE;
                        onehot_nxt  = MSB_CODE;
                    end else begin
                        state_nxt = ST_IDLE;
                        dac_nxt   = '0;
                        busy_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt  = ST_IDLE;
                dac_nxt    = '0;
                onehot_nxt = '0;
                busy_nxt   = 1'b0;
                valid_nxt  = 1'b0;
            end
        endcase
    end

    // Counter, trial register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_idx      <= '0;
            cur_ch       <= '0;
            dac_code     <= '0;
            bit_onehot   <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result_ch    <= '0;
            result_data  <= '0;
        end else begin
            bit_idx      <= bit_idx_nxt;
            cur_ch       <= cur_ch_nxt;
            dac_code     <= dac_nxt;
            bit_onehot   <= onehot_nxt;
            busy         <= busy_nxt;
            result_valid <= valid_nxt;
            result_ch    <= rch_nxt;
            result_data  <= data_nxt;
        end
    end

    sar_result_bank #(
        .NUM_CH   (NUM_CH),
        .RES_BITS (RES_BITS)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .we      (bank_we_c),
        .wch     (cur_ch),
        .wdata   (code_c),
        .results (results)
    );

endmodule

// File: tb/tb_sar_collector.sv
// Self-checking bench for sar_collector (default 8 channels x 10 bits).
// The comparator is modelled as cmp = (vin >= dac_code), or forced to a constant.
module tb_sar_collector;

    localparam int unsigned NUM_CH   = 8;
    localparam int unsigned RES_BITS = 10;
    localparam int unsigned CH_W     = 3;

    logic                       clk = 1'b0;
    logic                       reset, start, scan_en, abort, cmp, result_ready;
    logic [CH_W-1:0]            ch_sel, result_ch;
    logic [RES_BITS-1:0]        dac_code, bit_onehot, result_data;
    logic                       busy, result_valid;
    logic [NUM_CH*RES_BITS-1:0] results;

    logic [RES_BITS-1:0] vin;
    logic                cmp_force, cmp_val;

    typedef struct packed {
        logic [CH_W-1:0]     ch;
        logic [RES_BITS-1:0] data;
    } exp_t;

    exp_t                sb[$];
    logic [RES_BITS-1:0] bank_m [NUM_CH];
    int                  n_checks = 0;
    int                  n_fail   = 0;

    always #5 clk = ~clk;

    assign cmp = cmp_force ? cmp_val : (vin >= dac_code);

    sar_collector #(.NUM_CH(NUM_CH), .RES_BITS(RES_BITS)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .ch_sel       (ch_sel),
        .scan_en      (scan_en),
        .abort        (abort),
        .cmp          (cmp),
        .dac_code     (dac_code),
        .bit_onehot   (bit_onehot),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_ch    (result_ch),
        .result_data  (result_data),
        .results      (results)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge and record the expected result.
    task automatic push_start(input logic [CH_W-1:0] ch, input logic [RES_BITS-1:0] v,
                              input logic [RES_BITS-1:0] expv);
        ch_sel = ch;
        vin    = v;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        sb.push_back(exp_t'{ch: ch, data: expv});
    endtask

    // Bounded wait for result_valid; cyc reports edges waited.
    task automatic wait_valid(input int budget, output int cyc);
        cyc = 0;
        while (!result_valid && cyc < budget) begin
            tick();
            cyc++;
        end
    endtask

    function automatic logic [RES_BITS-1:0] vin_of(input logic [CH_W-1:0] ch);
        return 10'h100 + RES_BITS'(ch) * 10'h047;
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 0; scan_en = 0; abort = 0; result_ready = 0;
        ch_sel = '0; vin = '0; cmp_force = 0; cmp_val = 0;
        for (int k = 0; k < NUM_CH; k++) bank_m[k] = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if ({dac_code, bit_onehot, busy, result_valid, result_ch, result_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: dac=%h onehot=%h busy=%b valid=%b ch=%0d data=%h, required all 0",
                     dac_code, bit_onehot, busy, result_valid, result_ch, result_data);
        end
        n_checks++;
        if (results !== '0) begin
            n_fail++;
            $display("FAIL reset_bank: results=%h, required 0", results);
        end
    endtask

    task automatic test_convert();
        logic [RES_BITS-1:0] vins [4];
        logic [CH_W-1:0]     chs  [4];
        exp_t                e;
        int                  cyc;
        vins = '{10'h2A5, 10'h001, 10'h3FE, 10'h200};
        chs  = '{3'd3, 3'd1, 3'd5, 3'd2};
        for (int i = 0; i < 4; i++) begin
            push_start(chs[i], vins[i], vins[i]);
            wait_valid(20, cyc);
            n_checks++;
            if (!result_valid || cyc != RES_BITS) begin
                n_fail++;
                $display("FAIL convert_latency[%0d]: valid=%b after %0d cycles, required valid after %0d",
                         i, result_valid, cyc, RES_BITS);
            end
            e = sb.pop_front();
            n_checks++;
            if (result_ch !== e.ch || result_data !== e.data || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL convert_result[%0d]: ch=%0d data=%h busy=%b, required ch=%0d data=%h busy=1",
                         i, result_ch, result_data, busy, e.ch, e.data);
            end
            bank_m[e.ch] = e.data;
            n_checks++;
            if (results[e.ch*RES_BITS +: RES_BITS] !== e.data) begin
                n_fail++;
                $display("FAIL convert_bank[%0d]: slice=%h, required %h",
                         i, results[e.ch*RES_BITS +: RES_BITS], e.data);
            end
            result_ready = 1'b1;
            tick();
            result_ready = 1'b0;
            n_checks++;
            if (busy !== 1'b0 || result_valid !== 1'b0 || dac_code !== '0) begin
                n_fail++;
                $display("FAIL convert_idle[%0d]: busy=%b valid=%b dac=%h, required 0/0/0",
                         i, busy, result_valid, dac_code);
            end
        end
    endtask

    task automatic test_extremes();
        logic [RES_BITS-1:0] expw;
        exp_t                e;
        int                  cyc;
        cmp_force = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            cmp_val = (pass == 0);
            push_start((pass == 0) ? 3'd0 : 3'd7, '0, (pass == 0) ? 10'h3FF : 10'h000);
            for (int k = 0; k < RES_BITS; k++) begin
                expw = 10'h200 >> k;
                n_checks++;
                if (bit_onehot !== expw) begin
                    n_fail++;
                    $display("FAIL onehot_walk[%0d.%0d]: onehot=%h, required %h", pass, k, bit_onehot, expw);
                end
                tick();
            end
            wait_valid(5, cyc);
            e = sb.pop_front();
            n_checks++;
            if (!result_valid || result_ch !== e.ch || result_data !== e.data || bit_onehot !== '0) begin
                n_fail++;
                $display("FAIL extreme[%0d]: valid=%b ch=%0d data=%h onehot=%h, required 1/%0d/%h/0",
                         pass, result_valid, result_ch, result_data, bit_onehot, e.ch, e.data);
            end
            bank_m[e.ch] = e.data;
            result_ready = 1'b1;
            tick();
            result_ready = 1'b0;
        end
        cmp_force = 1'b0;
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   cyc;
        push_start(3'd4, 10'h155, 10'h155);
        wait_valid(20, cyc);
        e = sb.pop_front();
        for (int k = 0; k < 4; k++) begin
            ch_sel = 3'd1;
            vin    = 10'h3C3;
            start  = (k == 1);
            n_checks++;
            if (result_valid !== 1'b1 || result_ch !== e.ch || result_data !== e.data) begin
                n_fail++;
                $display("FAIL hold[%0d]: valid=%b ch=%0d data=%h, required 1/%0d/%h",
                         k, result_valid, result_ch, result_data, e.ch, e.data);
            end
            tick();
        end
        start = 1'b0;
        bank_m[e.ch] = e.data;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        tick(); tick();
        n_checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || dac_code !== '0) begin
            n_fail++;
            $display("FAIL hold_release: busy=%b valid=%b dac=%h, required idle", busy, result_valid, dac_code);
        end
        n_checks++;
        if (results[1*RES_BITS +: RES_BITS] !== bank_m[1]) begin
            n_fail++;
            $display("FAIL start_ignored: ch1 slice=%h, required %h", results[1*RES_BITS +: RES_BITS], bank_m[1]);
        end
    endtask

    task automatic test_abort();
        exp_t e;
        int   cyc;
        bit   seen;
        // abort in the 5th CONVERT cycle on ch 4
        push_start(3'd4, 10'h0AA, 10'h0AA);
        void'(sb.pop_back());
        for (int k = 0; k < 4; k++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || dac_code !== '0 || bit_onehot !== '0 || result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: busy=%b dac=%h onehot=%h valid=%b, required 0", busy, dac_code,
                     bit_onehot, result_valid);
        end
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (result_valid) seen = 1;
            tick();
        end
        n_checks++;
        if (seen || results[4*RES_BITS +: RES_BITS] !== 10'h155) begin
            n_fail++;
            $display("FAIL abort_bank: valid_seen=%b ch4=%h, required 0/155", seen,
                     results[4*RES_BITS +: RES_BITS]);
        end
        // abort with start in IDLE: start wins
        abort = 1'b1;
        push_start(3'd5, 10'h0F0, 10'h0F0);
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || dac_code !== 10'h200) begin
            n_fail++;
            $display("FAIL abort_start_idle: busy=%b dac=%h, required 1/200", busy, dac_code);
        end
        wait_valid(20, cyc);
        // abort in DONE has no effect
        abort = 1'b1;
        tick();
        abort = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (result_valid !== 1'b1 || result_ch !== e.ch || result_data !== e.data) begin
            n_fail++;
            $display("FAIL abort_done: valid=%b ch=%0d data=%h, required 1/%0d/%h",
                     result_valid, result_ch, result_data, e.ch, e.data);
        end
        bank_m[e.ch] = e.data;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t            e;
        int              cyc;
        logic [CH_W-1:0] nch;
        scan_en      = 1'b1;
        result_ready = 1'b1;
        push_start(3'd6, vin_of(3'd6), vin_of(3'd6));
        for (int i = 0; i < 4; i++) begin
            wait_valid(20, cyc);
            n_checks++;
            if (!result_valid || (i == 0 ? cyc : cyc + 1) != ((i == 0) ? RES_BITS : RES_BITS + 1)) begin
                n_fail++;
                $display("FAIL scan_gap[%0d]: valid=%b gap=%0d, required %0d", i, result_valid,
                         (i == 0) ? cyc : cyc + 1, (i == 0) ? RES_BITS : RES_BITS + 1);
            end
            e = sb.pop_front();
            n_checks++;
            if (result_ch !== e.ch || result_data !== e.data) begin
                n_fail++;
                $display("FAIL scan_result[%0d]: ch=%0d data=%h, required ch=%0d data=%h",
                         i, result_ch, result_data, e.ch, e.data);
            end
            bank_m[e.ch] = e.data;
            if (i < 3) begin
                nch = (e.ch == CH_W'(NUM_CH - 1)) ? '0 : e.ch + 3'd1;
                vin = vin_of(nch);
                sb.push_back(exp_t'{ch: nch, data: vin_of(nch)});
            end else begin
                scan_en = 1'b0;
            end
            tick();
        end
        result_ready = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL scan_end: busy=%b pending=%0d, required 0/0", busy, sb.size());
        end
    endtask

    task automatic test_bank_persist();
        for (int k = 0; k < NUM_CH; k++) begin
            n_checks++;
            if (results[k*RES_BITS +: RES_BITS] !== bank_m[k]) begin
                n_fail++;
                $display("FAIL bank[%0d]: %h, required %h", k, results[k*RES_BITS +: RES_BITS], bank_m[k]);
            end
        end
    endtask

    task automatic test_reset_mid_convert();
        push_start(3'd2, 10'h123, 10'h123);
        void'(sb.pop_back());
        tick(); tick(); tick();
        n_checks++;
        if (bit_onehot !== 10'h040) begin
            n_fail++;
            $display("FAIL reset_mid_pos: onehot=%h, required 040", bit_onehot);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if ({dac_code, bit_onehot, busy, result_valid, result_ch, result_data} !== '0 || results !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: dac=%h onehot=%h busy=%b valid=%b ch=%0d data=%h results=%h, required 0",
                     dac_code, bit_onehot, busy, result_valid, result_ch, result_data, results);
        end
        reset = 1'b0;
        tick(); tick();
        n_checks++;
        if (busy !== 1'b0 || dac_code !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_idle: busy=%b dac=%h, required 0/0", busy, dac_code);
        end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_extremes();
        test_backpressure();
        test_abort();
        test_back_to_back();
        test_bank_persist();
        test_reset_mid_convert();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
